// File: rtl/alu_arbiter_if.sv
// Bundle of handshake and ALU-side signals for alu_arbiter.
// slave  : view taken by the arbiter itself.
// master : view taken by the surrounding logic (requesters, response sink, external ALU).
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [SEL_W-1:0] req0_sel;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [SEL_W-1:0] req1_sel;

    logic             resp0_valid;
    logic             resp1_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_zero;
    logic             resp_err;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_select;
    logic [WIDTH-1:0] alu_out;
    logic             alu_flag;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  resp_ready, alu_out, alu_flag,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_data, resp_zero, resp_err,
        output alu_a, alu_b, alu_select, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output resp_ready, alu_out, alu_flag,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_data, resp_zero, resp_err,
        input  alu_a, alu_b, alu_select, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU between two
// requesters. One operation in flight: IDLE (accept) -> EXEC (capture ALU) -> RESP.
// Optional feature macro: ALU_OP_CHECK_EN -- when defined, illegal selects are
// accepted but answered directly from IDLE with resp_err=1 and zero data.
module alu_arbiter #(
    parameter int   WIDTH     = 32,
    parameter int   SEL_W     = 4,
    parameter logic START_PTR = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;

`ifdef ALU_OP_CHECK_EN
    // Legal selects: add, sub, slt and the 01xx logic group.
    function automatic logic op_legal(input logic [SEL_W-1:0] sel);
        logic legal;
        if ((sel == 4'b0000) || (sel == 4'b0010) || (sel == 4'b1010) || (sel[3:2] == 2'b01)) begin
            legal = 1'b1;
        end else begin
            legal = 1'b0;
        end
        return legal;
    endfunction
`endif

    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             rv0_q, rv0_d;
    logic             rv1_q, rv1_d;

    logic             grant_s;
    logic             accept_s;
    logic             illegal_s;
    logic [WIDTH-1:0] g_a_s;
    logic [WIDTH-1:0] g_b_s;
    logic [SEL_W-1:0] g_sel_s;

    // Round-robin grant: pointer breaks ties, otherwise the lone valid requester wins.
    always_comb begin
        grant_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ptr_q;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        accept_s = (state_q == S_IDLE) && (bus.req0_valid || bus.req1_valid);
        g_a_s    = grant_s ? bus.req1_a   : bus.req0_a;
        g_b_s    = grant_s ? bus.req1_b   : bus.req0_b;
        g_sel_s  = grant_s ? bus.req1_sel : bus.req0_sel;
`ifdef ALU_OP_CHECK_EN
        illegal_s = accept_s && !op_legal(g_sel_s);
`else
        illegal_s = 1'b0;
`endif
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence and all datapath registers.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        data_d  = data_q;
        zero_d  = zero_q;
        err_d   = err_q;
        rv0_d   = rv0_q;
        rv1_d   = rv1_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    a_d     = g_a_s;
                    b_d     = g_b_s;
                    sel_d   = g_sel_s;
                    owner_d = grant_s;
                    ptr_d   = ~grant_s;
                    if (illegal_s) begin
                        // Answer straight away without touching the ALU.
                        data_d  = {WIDTH{1'b0}};
                        zero_d  = 1'b0;
                        err_d   = 1'b1;
                        rv0_d   = ~grant_s;
                        rv1_d   = grant_s;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_EXEC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                data_d  = bus.alu_out;
                zero_d  = bus.alu_flag;
                err_d   = 1'b0;
                rv0_d   = ~owner_q;
                rv1_d   = owner_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    rv0_d   = 1'b0;
                    rv1_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                rv0_d   = 1'b0;
                rv1_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= START_PTR;
            owner_q <= 1'b0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sel_q   <= {SEL_W{1'b0}};
            data_q  <= {WIDTH{1'b0}};
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
        end
    end

    assign bus.req0_ready  = accept_s && !grant_s;
    assign bus.req1_ready  = accept_s && grant_s;
    assign bus.resp0_valid = rv0_q;
    assign bus.resp1_valid = rv1_q;
    assign bus.resp_data   = data_q;
    assign bus.resp_zero   = zero_q;
    assign bus.resp_err    = err_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_select  = sel_q;
    assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes hand-computed expectations,
// a monitor process pops and compares on every response handshake.
module tb_alu_arbiter;

    logic clk;
    logic reset;

    alu_arbiter_if #(.WIDTH(32), .SEL_W(4)) bus ();

    alu_arbiter #(.WIDTH(32), .SEL_W(4), .START_PTR(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model.
    always_comb begin
        case (bus.alu_select)
            4'b0000: bus.alu_out = bus.alu_a + bus.alu_b;
            4'b0010: bus.alu_out = bus.alu_a - bus.alu_b;
            4'b1010: bus.alu_out = {31'd0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
            4'b0100: bus.alu_out = bus.alu_a & bus.alu_b;
            4'b0101: bus.alu_out = bus.alu_a | bus.alu_b;
            4'b0110: bus.alu_out = bus.alu_a ^ bus.alu_b;
            4'b0111: bus.alu_out = ~(bus.alu_a | bus.alu_b);
            default: bus.alu_out = bus.alu_a + bus.alu_b;
        endcase
        bus.alu_flag = (bus.alu_out == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every taken response against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && (bus.resp0_valid || bus.resp1_valid) && bus.resp_ready) begin
                chk("one_owner", {31'd0, bus.resp0_valid & bus.resp1_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_owner", {31'd0, bus.resp1_valid}, e.id[31:0]);
                    chk("resp_data", bus.resp_data, e.data);
                    chk("resp_zero", {31'd0, bus.resp_zero}, {31'd0, e.zero});
                    chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic push_exp(input int id, input logic [31:0] d, input logic z, input logic er);
        exp_t e;
        e.id = id; e.data = d; e.zero = z; e.err = er;
        exp_q.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, input logic [31:0] ed, input logic ez, input logic ee);
        logic got;
        got = 1'b0;
        if (id == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel; bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (id == 0) ? bus.req0_ready : bus.req1_ready;
        end
        chk("accept", {31'd0, got}, 32'd1);
        if (got) push_exp(id, ed, ez, ee);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_resp(input int id, input int exp_lat);
        int   n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            seen = (id == 0) ? bus.resp0_valid : bus.resp1_valid;
        end
        chk("latency", n, exp_lat);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req0_sel = 4'd0;
        bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_sel = 4'd0;
        bus.resp_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_rv0", {31'd0, bus.resp0_valid}, 32'd0);
        chk("rst_rv1", {31'd0, bus.resp1_valid}, 32'd0);
        chk("rst_data", bus.resp_data, 32'd0);
        chk("rst_zero", {31'd0, bus.resp_zero}, 32'd0);
        chk("rst_err", {31'd0, bus.resp_err}, 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_sel", {28'd0, bus.alu_select}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: single add on requester 0
        send(0, 32'd5, 32'd3, 4'b0000, 32'd8, 1'b0, 1'b0);
        wait_resp(0, 2);
        drain();

        // 2: contention after reset, alternating grants
        do_reset();
        bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_sel = 4'b0000;
        bus.req1_a = 32'd7; bus.req1_b = 32'd7; bus.req1_sel = 4'b0010;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            got = -1;
            for (int i = 0; i < 20 && got < 0; i++) begin
                @(negedge clk);
                if (bus.req0_ready) got = 0;
                else if (bus.req1_ready) got = 1;
                else got = -1;
            end
            chk("grant_order", got, g % 2);
            if (got == 0) push_exp(0, 32'd3, 1'b0, 1'b0);
            else if (got == 1) push_exp(1, 32'd0, 1'b1, 1'b0);
            @(posedge clk);
            #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain();

        // 3: back-pressure on a requester 1 response
        bus.resp_ready = 1'b0;
        send(1, 32'h0000F0F0, 32'h0000FF00, 4'b0100, 32'h0000F000, 1'b0, 1'b0);
        wait_resp(1, 2);
        #1;
        bus.req0_a = 32'd9; bus.req0_b = 32'd1; bus.req0_sel = 4'b0000; bus.req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rv1", {31'd0, bus.resp1_valid}, 32'd1);
            chk("bp_data", bus.resp_data, 32'h0000F000);
            chk("bp_ready0", {31'd0, bus.req0_ready}, 32'd0);
            chk("bp_ready1", {31'd0, bus.req1_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_still_resp", {31'd0, bus.req0_ready}, 32'd0);
        @(negedge clk);
        chk("bp_idle", {31'd0, bus.busy}, 32'd0);
        chk("bp_next_ready", {31'd0, bus.req0_ready}, 32'd1);
        push_exp(0, 32'd10, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        drain();

        // 4: signed less-than both ways
        send(0, 32'hFFFFFFFF, 32'd1, 4'b1010, 32'd1, 1'b0, 1'b0);
        drain();
        send(0, 32'd1, 32'hFFFFFFFF, 4'b1010, 32'd0, 1'b1, 1'b0);
        drain();

        // Select outside the legal set
`ifdef ALU_OP_CHECK_EN
        send(0, 32'd5, 32'd6, 4'b1111, 32'd0, 1'b0, 1'b1);
        wait_resp(0, 1);
        drain();
`else
        send(1, 32'd2, 32'd2, 4'b1111, 32'd4, 1'b0, 1'b0);
        @(negedge clk);
        chk("fwd_sel", {28'd0, bus.alu_select}, 32'h0000000F);
        drain();
`endif

        // 5: reset while in EXEC
        send(1, 32'd2, 32'd3, 4'b0000, 32'd5, 1'b0, 1'b0);
        @(negedge clk);
        chk("exec_busy", {31'd0, bus.busy}, 32'd1);
        chk("exec_alu_a", bus.alu_a, 32'd2);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_rv0", {31'd0, bus.resp0_valid}, 32'd0);
        chk("mid_rst_rv1", {31'd0, bus.resp1_valid}, 32'd0);
        chk("mid_rst_data", bus.resp_data, 32'd0);
        chk("mid_rst_alu_b", bus.alu_b, 32'd0);
        #1;
        bus.req0_a = 32'd4; bus.req0_b = 32'd4; bus.req0_sel = 4'b0000;
        bus.req1_a = 32'd1; bus.req1_b = 32'd1; bus.req1_sel = 4'b0000;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("ptr_rst_r0", {31'd0, bus.req0_ready}, 32'd1);
        chk("ptr_rst_r1", {31'd0, bus.req1_ready}, 32'd0);
        push_exp(0, 32'd8, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
